// File: rtl/ldm_result_reader_pkg.sv
// ldm_result_reader_pkg
//   Shared parameters, FSM state encoding, FIFO entry layout and the
//   linear-to-port LDM address mapping used by the result reader.
package ldm_result_reader_pkg;

  localparam int PE_NUM_BITS   = 5;
  localparam int LDM_NUM_BITS  = 2;
  localparam int LDM_ADDR_BITS = 6;
  localparam int WORD_BITS     = 16;

  localparam int RESULT_COUNT  = 1280;
  localparam int ROW_VALID     = 20;
  localparam int ROW_STRIDE    = 32;

  localparam int ADDR_BITS  = PE_NUM_BITS + LDM_NUM_BITS + LDM_ADDR_BITS;
  localparam int LIN_BITS   = PE_NUM_BITS + LDM_ADDR_BITS;
  localparam int INDEX_BITS = 16;
  localparam int COL_BITS   = $clog2(ROW_VALID);
  // Linear step taken when the column counter wraps: skips the unused
  // tail of the current row and lands on column 0 of the next one.
  localparam int ROW_SKIP   = ROW_STRIDE - ROW_VALID + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [INDEX_BITS-1:0] index;
    logic [WORD_BITS-1:0]  data;
  } result_entry_t;

  // Results are PE-interleaved: low bits of the linear word select the PE,
  // high bits select the word inside that PE. The bank field is always 0.
  function automatic logic [ADDR_BITS-1:0] ldm_port_addr(input logic [LIN_BITS-1:0] lin);
    return {lin[PE_NUM_BITS-1:0], {LDM_NUM_BITS{1'b0}}, lin[LIN_BITS-1:PE_NUM_BITS]};
  endfunction

endpackage

// File: rtl/ldm_result_reader_fifo.sv
// result_skid_fifo
//   Two-entry synchronous FIFO of {last, index, data} result beats.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     clr          synchronous flush (drops all entries)
//     push, push_entry   write side (ignored when full and not popping)
//     pop          read side (ignored when empty)
//     head         oldest entry, combinationally visible
//     empty, full, count   occupancy status
module result_skid_fifo
  import ldm_result_reader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  result_entry_t push_entry,
  input  logic          pop,
  output result_entry_t head,
  output logic          empty,
  output logic          full,
  output logic [1:0]    count
);

  result_entry_t mem [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle; the freed slot is the one being written.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (clr) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ldm_result_reader.sv
// ldm_result_reader
//   Drains RESULT_COUNT inference results from LDM after the core completes
//   and presents them as a ready/valid word stream.
//   Ports:
//     CLK, RST          clock, asynchronous active-high reset
//     complete_in       core completion; rising edge starts a drain
//     abort_in          synchronous abort back to idle
//     ldm_addra_out     LDM read address {pe, bank=0, word}
//     ldm_ena_out       LDM read enable
//     ldm_douta_in      LDM read data, one cycle after enable
//     busy_out          block owns the LDM port
//     m_data_out, m_index_out, m_last_out, m_valid_out, m_ready_in   result stream
//     done_out          one-cycle pulse after the last beat is accepted
module ldm_result_reader
  import ldm_result_reader_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  complete_in,
  input  logic                  abort_in,
  output logic [ADDR_BITS-1:0]  ldm_addra_out,
  output logic                  ldm_ena_out,
  input  logic [WORD_BITS-1:0]  ldm_douta_in,
  output logic                  busy_out,
  output logic [WORD_BITS-1:0]  m_data_out,
  output logic                  m_valid_out,
  input  logic                  m_ready_in,
  output logic                  m_last_out,
  output logic [INDEX_BITS-1:0] m_index_out,
  output logic                  done_out
);

  state_t                state_reg, state_next;
  logic                  complete_q_reg;
  logic [INDEX_BITS-1:0] idx_reg;
  logic [COL_BITS-1:0]   col_reg;
  logic [LIN_BITS-1:0]   lin_reg;
  logic                  pend_reg;
  logic [INDEX_BITS-1:0] pend_index_reg;
  logic                  pend_last_reg;

  logic                  start;
  logic                  issue;
  logic                  pop;
  logic                  is_last;
  logic                  credit_ok;
  logic                  clear;
  logic [2:0]            occupancy;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [1:0]            fifo_count;
  result_entry_t         head;
  result_entry_t         push_entry;

  assign start     = complete_in & ~complete_q_reg;
  assign pop       = m_valid_out & m_ready_in;
  assign is_last   = (idx_reg == INDEX_BITS'(RESULT_COUNT - 1));
  assign occupancy = {1'b0, fifo_count} + {2'b00, pend_reg};
  // Two credits cover FIFO entries plus the read in flight. When a read is
  // in flight and the head leaves this cycle, the slot is reused at once,
  // which sustains one beat per cycle. A FIFO drained from full only
  // regains its credit on the following cycle.
  assign credit_ok = (~fifo_full & (occupancy < 3'd2)) | (pop & pend_reg);
  assign clear     = abort_in | (state_reg == ST_DONE);

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // The first read goes out in the start cycle itself.
        if (start) begin
          issue      = 1'b1;
          state_next = is_last ? ST_DRAIN : ST_READ;
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (is_last) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last-flagged entry is always the final one in the FIFO.
        if (pop && head.last) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (abort_in) begin
      issue      = 1'b0;
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      // Held at 1 so a complete level present across reset is not taken
      // as a fresh edge, and start stays low while reset is asserted.
      complete_q_reg <= 1'b1;
      idx_reg        <= '0;
      col_reg        <= '0;
      lin_reg        <= '0;
      pend_reg       <= 1'b0;
      pend_index_reg <= '0;
      pend_last_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      complete_q_reg <= complete_in;
      if (clear) begin
        idx_reg        <= '0;
        col_reg        <= '0;
        lin_reg        <= '0;
        pend_reg       <= 1'b0;
        pend_index_reg <= '0;
        pend_last_reg  <= 1'b0;
      end else begin
        pend_reg <= issue;
        if (issue) begin
          pend_index_reg <= idx_reg;
          pend_last_reg  <= is_last;
          idx_reg        <= idx_reg + INDEX_BITS'(1);
          if (col_reg == COL_BITS'(ROW_VALID - 1)) begin
            col_reg <= '0;
            lin_reg <= lin_reg + LIN_BITS'(ROW_SKIP);
          end else begin
            col_reg <= col_reg + COL_BITS'(1);
            lin_reg <= lin_reg + LIN_BITS'(1);
          end
        end
      end
    end
  end

  assign push_entry = '{last: pend_last_reg, index: pend_index_reg, data: ldm_douta_in};

  result_skid_fifo u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .clr        (abort_in),
    .push       (pend_reg),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  assign ldm_addra_out = ldm_port_addr(lin_reg);
  assign ldm_ena_out   = issue;
  assign busy_out      = (state_reg != ST_IDLE) | issue;
  assign done_out      = (state_reg == ST_DONE);
  assign m_valid_out   = ~fifo_empty;
  // Stale FIFO contents are masked so an idle stream reads as all zeros.
  assign m_data_out    = m_valid_out ? head.data  : '0;
  assign m_index_out   = m_valid_out ? head.index : '0;
  assign m_last_out    = m_valid_out & head.last;

endmodule

// File: tb/tb_ldm_result_reader.sv
// tb_ldm_result_reader
//   Self-checking bench: LDM memory model with random contents, a reference
//   built from the packed-layout arithmetic, a table of hand-derived
//   addresses, and sequences for backpressure, retrigger, abort and reset.
module tb_ldm_result_reader;
  import ldm_result_reader_pkg::*;

  localparam int N        = RESULT_COUNT;
  localparam int PE_COUNT = 1 << PE_NUM_BITS;
  localparam int MEM_SIZE = 1 << ADDR_BITS;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  complete_in = 1'b0;
  logic                  abort_in = 1'b0;
  logic [ADDR_BITS-1:0]  ldm_addra_out;
  logic                  ldm_ena_out;
  logic [WORD_BITS-1:0]  ldm_douta_in = '0;
  logic                  busy_out;
  logic [WORD_BITS-1:0]  m_data_out;
  logic                  m_valid_out;
  logic                  m_ready_in = 1'b0;
  logic                  m_last_out;
  logic [INDEX_BITS-1:0] m_index_out;
  logic                  done_out;

  ldm_result_reader dut (
    .CLK           (CLK),
    .RST           (RST),
    .complete_in   (complete_in),
    .abort_in      (abort_in),
    .ldm_addra_out (ldm_addra_out),
    .ldm_ena_out   (ldm_ena_out),
    .ldm_douta_in  (ldm_douta_in),
    .busy_out      (busy_out),
    .m_data_out    (m_data_out),
    .m_valid_out   (m_valid_out),
    .m_ready_in    (m_ready_in),
    .m_last_out    (m_last_out),
    .m_index_out   (m_index_out),
    .done_out      (done_out)
  );

  always #5 CLK = ~CLK;

  // LDM model: synchronous read, data valid the cycle after enable.
  logic [WORD_BITS-1:0] ldm_mem [0:MEM_SIZE-1];
  always @(posedge CLK) begin
    if (ldm_ena_out) ldm_douta_in <= ldm_mem[ldm_addra_out];
  end

  // ---------------- reference model ----------------
  function automatic int exp_lin(input int i);
    return i + (i / ROW_VALID) * (ROW_STRIDE - ROW_VALID);
  endfunction

  function automatic logic [ADDR_BITS-1:0] exp_addr(input int i);
    int lin;
    lin = exp_lin(i);
    return ADDR_BITS'((lin % PE_COUNT) * (1 << (LDM_NUM_BITS + LDM_ADDR_BITS)) + lin / PE_COUNT);
  endfunction

  function automatic logic [WORD_BITS-1:0] exp_data(input int i);
    return ldm_mem[exp_addr(i)];
  endfunction

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0: low, 1: high, 2: random
  int issued, accepted, max_ahead;
  int first_valid_cyc, first_beat_cyc, last_cyc, done_cyc, start_cyc;
  int done_cnt = 0;
  int run_done_base;
  logic [ADDR_BITS-1:0] addr_log [0:N-1];
  logic                 last_log [0:N-1];
  logic                 mon_pop;
  logic                 prev_hold = 1'b0;
  logic                 prev_abort = 1'b0;
  logic [WORD_BITS-1:0] prev_data;
  logic [INDEX_BITS-1:0] prev_index;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0:       m_ready_in = 1'b0;
      1:       m_ready_in = 1'b1;
      default: m_ready_in = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: samples mid-cycle, one decision per clock.
  always @(negedge CLK) begin
    if (RST) begin
      prev_hold = 1'b0;
    end else begin
      mon_pop = m_valid_out && m_ready_in;
      if (ldm_ena_out) begin
        chk("issue_addr", 64'(ldm_addra_out), 64'(exp_addr(issued)));
        if (issued < N) addr_log[issued] = ldm_addra_out;
        issued++;
      end
      if (prev_hold && !prev_abort) begin
        chk("hold_valid", 64'(m_valid_out), 64'd1);
        chk("hold_data", 64'(m_data_out), 64'(prev_data));
        chk("hold_index", 64'(m_index_out), 64'(prev_index));
      end
      if (m_valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (mon_pop) begin
        chk("beat_index", 64'(m_index_out), 64'(accepted));
        chk("beat_data", 64'(m_data_out), 64'(exp_data(accepted)));
        chk("beat_last", 64'(m_last_out), 64'(accepted == N - 1));
        if (accepted < N) last_log[accepted] = m_last_out;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        if (m_last_out) last_cyc = cyc;
        accepted++;
      end
      if (issued - accepted > max_ahead) max_ahead = issued - accepted;
      if (done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_hold  = m_valid_out && !m_ready_in;
      prev_data  = m_data_out;
      prev_index = m_index_out;
      prev_abort = abort_in;
    end
  end

  // ---------------- sequences ----------------
  task automatic clr_stats();
    issued = 0; accepted = 0; max_ahead = 0;
    first_valid_cyc = -1; first_beat_cyc = -1; last_cyc = -1; done_cyc = -1;
    run_done_base = done_cnt;
  endtask

  task automatic start_run(input bit hold_high);
    @(posedge CLK); #1;
    clr_stats();
    complete_in = 1'b1;
    start_cyc = cyc;
    @(negedge CLK);
    chk("start_busy", 64'(busy_out), 64'd1);
    chk("start_ena", 64'(ldm_ena_out), 64'd1);
    chk("start_addr", 64'(ldm_addra_out), 64'd0);
    if (!hold_high) begin
      @(posedge CLK); #1;
      complete_in = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == run_done_base; k++) @(negedge CLK);
    repeat (5) @(negedge CLK);
    chk("done_once", 64'(done_cnt - run_done_base), 64'd1);
  endtask

  task automatic check_run();
    chk("accepted_total", 64'(accepted), 64'(N));
    chk("issued_total", 64'(issued), 64'(N));
    chk("max_ahead_le2", 64'(max_ahead <= 2), 64'd1);
    chk("done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    chk("busy_idle", 64'(busy_out), 64'd0);
  endtask

  typedef struct {
    int   idx;
    int   pe;
    int   word;
    logic last;
  } vec_t;
  vec_t tbl [8];
  int   base_done;

  initial begin
    // Hand-derived from the packed layout (20 valid of 32 per row).
    tbl[0] = '{idx: 0,    pe: 0,  word: 0,  last: 1'b0};
    tbl[1] = '{idx: 19,   pe: 19, word: 0,  last: 1'b0};
    tbl[2] = '{idx: 20,   pe: 0,  word: 1,  last: 1'b0};
    tbl[3] = '{idx: 39,   pe: 19, word: 1,  last: 1'b0};
    tbl[4] = '{idx: 40,   pe: 0,  word: 2,  last: 1'b0};
    tbl[5] = '{idx: 640,  pe: 0,  word: 32, last: 1'b0};
    tbl[6] = '{idx: 1260, pe: 0,  word: 63, last: 1'b0};
    tbl[7] = '{idx: 1279, pe: 19, word: 63, last: 1'b1};

    for (int a = 0; a < MEM_SIZE; a++) ldm_mem[a] = WORD_BITS'($urandom);
    clr_stats();

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ena", 64'(ldm_ena_out), 64'd0);
    chk("rst_addr", 64'(ldm_addra_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_valid", 64'(m_valid_out), 64'd0);
    chk("rst_data", 64'(m_data_out), 64'd0);
    chk("rst_index", 64'(m_index_out), 64'd0);
    chk("rst_last", 64'(m_last_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    RST = 1'b0;
    repeat (3) @(posedge CLK);

    // A: full-rate drain
    ready_mode = 1;
    start_run(1'b0);
    wait_done(3000);
    check_run();
    chk("first_valid_latency", 64'(first_valid_cyc), 64'(start_cyc + 2));
    chk("back_to_back", 64'(last_cyc - first_beat_cyc), 64'(N - 1));
    for (int t = 0; t < 8; t++) begin
      chk("tbl_pe", 64'(addr_log[tbl[t].idx][ADDR_BITS-1 -: PE_NUM_BITS]), 64'(tbl[t].pe));
      chk("tbl_bank", 64'(addr_log[tbl[t].idx][LDM_ADDR_BITS +: LDM_NUM_BITS]), 64'd0);
      chk("tbl_word", 64'(addr_log[tbl[t].idx][LDM_ADDR_BITS-1:0]), 64'(tbl[t].word));
      chk("tbl_last", 64'(last_log[tbl[t].idx]), 64'(tbl[t].last));
    end

    // B: random backpressure, with a stray edge mid-drain
    ready_mode = 2;
    start_run(1'b0);
    repeat (300) @(posedge CLK);
    #1 complete_in = 1'b1;
    @(posedge CLK); #1 complete_in = 1'b0;
    wait_done(20000);
    check_run();

    // C: stall 50 cycles on the first beat
    ready_mode = 0;
    start_run(1'b0);
    for (int k = 0; k < 20 && first_valid_cyc < 0; k++) @(negedge CLK);
    chk("stall_first_valid", 64'(first_valid_cyc >= 0), 64'd1);
    begin
      bit hold_ok;
      hold_ok = 1'b1;
      repeat (50) begin
        @(negedge CLK);
        if (!(m_valid_out && m_index_out == 0 && m_data_out == exp_data(0))) hold_ok = 1'b0;
      end
      chk("stall_hold_idx0", 64'(hold_ok), 64'd1);
    end
    chk("stall_issued", 64'(issued), 64'd2);
    ready_mode = 1;
    wait_done(3000);
    check_run();

    // D: complete held high, then a second edge after DONE
    start_run(1'b1);
    wait_done(3000);
    repeat (1700) @(posedge CLK);
    chk("no_retrigger_done", 64'(done_cnt - run_done_base), 64'd1);
    chk("no_retrigger_issue", 64'(issued), 64'(N));
    #1 complete_in = 1'b0;
    repeat (3) @(posedge CLK);
    start_run(1'b0);
    wait_done(3000);
    check_run();

    // E: abort around index 600
    start_run(1'b0);
    for (int k = 0; k < 5000 && accepted < 600; k++) @(negedge CLK);
    chk("abort_reached_600", 64'(accepted >= 600), 64'd1);
    base_done = done_cnt;
    @(posedge CLK); #1 abort_in = 1'b1;
    @(posedge CLK); #1 abort_in = 1'b0;
    @(negedge CLK);
    chk("abort_valid", 64'(m_valid_out), 64'd0);
    chk("abort_busy", 64'(busy_out), 64'd0);
    chk("abort_ena", 64'(ldm_ena_out), 64'd0);
    repeat (20) @(negedge CLK);
    chk("abort_no_done", 64'(done_cnt), 64'(base_done));
    start_run(1'b0);
    wait_done(3000);
    check_run();

    // F: asynchronous reset mid-READ
    start_run(1'b0);
    repeat (100) @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_ena", 64'(ldm_ena_out), 64'd0);
    chk("arst_addr", 64'(ldm_addra_out), 64'd0);
    chk("arst_busy", 64'(busy_out), 64'd0);
    chk("arst_valid", 64'(m_valid_out), 64'd0);
    chk("arst_data", 64'(m_data_out), 64'd0);
    chk("arst_index", 64'(m_index_out), 64'd0);
    chk("arst_last", 64'(m_last_out), 64'd0);
    chk("arst_done", 64'(done_out), 64'd0);
    @(posedge CLK);
    @(posedge CLK); #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    start_run(1'b0);
    wait_done(3000);
    check_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
